dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
- Sits between fetch and decode of the dual-issue pipeline.
- Buffers fetched instruction/PC slots in a small circular queue.
- Each cycle it decides whether the two oldest slots issue as a pair (lane A + lane B) or only the oldest issues (lane A alone).
- Splits a pair on an intra-pair RAW hazard, a memory-port conflict or a control-flow instruction in lane A; honours downstream stall and flush.

Parameters:
- DEPTH, 4, queue capacity in instruction slots; power of 2, at least 4.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_pc_a  in  XLEN  PC of older fetched instruction
- in_instr_a  in  XLEN  older fetched instruction
- in_vld_a  in  1  older slot valid
- in_pc_b  in  XLEN  PC of younger fetched instruction
- in_instr_b  in  XLEN  younger fetched instruction
- in_vld_b  in  1  younger slot valid
- in_ready  out  1  queue can accept a pair: (DEPTH - count) >= 2, from registered count
- ex_stall  in  1  downstream cannot accept; hold outputs, pop nothing
- flush  in  1  discard queue and outputs
- out_pc_a, out_instr_a  out  XLEN each  issued lane A
- out_vld_a  out  1  lane A valid
- out_pc_b, out_instr_b  out  XLEN each  issued lane B
- out_vld_b  out  1  lane B valid
- split  out  1  registered; 1 when h0 and h1 were both present and only h0 issued
- count  out  clog2(DEPTH)+1  occupied slots

Behaviour:
- Reset (async): pointers=0, count=0, all out_* =0, split=0; in_ready=1.
- Push: on an edge with in_ready=1, valid slots are written in order, A before B, compacted. Push count is 0, 1 or 2. Pushes while in_ready=0 are ignored; fetch must hold its inputs.
- Issue, on an edge with ex_stall=0 and flush=0. h0 and h1 are the two oldest slots, taken from registered state; a slot pushed at edge N is eligible at edge N+1.
  - count=0: out_vld_a=0, out_vld_b=0.
  - count>=1: h0 -> lane A, out_vld_a=1.
  - h1 -> lane B (out_vld_b=1) only when count>=2 and none of the following hold:
    - RAW: h0 writes rd, rd!=0, and h1 reads rs1 or rs2 equal to that rd.
    - Memory conflict: both h0 and h1 are load (0000011) or store (0100011).
    - Control flow: h0 is branch (1100011), JAL (1101111) or JALR (1100111).
  - Otherwise out_vld_b=0. split=1 iff count>=2 and h1 was not issued.
  - Pop count = number of lanes issued.
- Opcode classes:
  - Writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - Reads rs1: all except 0110111, 0010111, 1101111.
  - Reads rs2: 0110011, 0100011, 1100011.
  - Unknown opcodes: treated as writing rd and reading rs1 and rs2 (conservative).
- ex_stall=1: all out_* and split hold their values; pop=0; pushes still allowed.
- Simultaneous push and pop in one edge: count_next = count + push - pop. Pointers wrap modulo DEPTH.
- flush=1 (highest priority, over push and stall): on that edge pointers=0, count=0, out_vld_a=0, out_vld_b=0, split=0; inputs presented that cycle are dropped.
- Reset asserted mid-operation clears everything immediately, same as power-on reset.

Optional Feature:
- Macro: SCHED_STATS_EN.
- When defined, add ports:
  - stat_dual  out  32  count of edges with both lanes issued.
  - stat_single  out  32  count of edges with split=1.
  - Both wrap at 2^32, clear on rst and on flush, and do not count stalled edges.
- When not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream -> immediately count=0, out_vld_a=0, out_vld_b=0, in_ready=1.
- Independent pair: push A=0x00500093 (addi x1,x0,5) at PC 0x0, B=0x00700113 (addi x2,x0,7) at PC 0x4 -> one edge later out_vld_a=1 (pc 0x0), out_vld_b=1 (pc 0x4), split=0, count=0.
- RAW: push 0x00500093 (addi x1,x0,5) then 0x001081B3 (add x3,x1,x1) -> first issue A only with split=1; next edge the add issues on lane A with out_vld_b=0.
- Memory conflict: push 0x00012083 (lw x1,0(x2)) then 0x00412183 (lw x3,4(x2)) -> issued on separate edges with split=1; a lw paired with an addi dual-issues.
- Stall/full: ex_stall=1, push two pairs -> count=4, in_ready=0, outputs unchanged, third pair ignored; release ex_stall -> two pairs issue over two edges and in_ready=1 again.
- Flush: count=3 with outputs valid, flush=1 together with a valid push -> next edge count=0, out_vld_a=0, out_vld_b=0, pushed pair dropped.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler between fetch and decode.
// Fetched slots go into a circular queue. Each cycle the two oldest slots issue
// as a pair, or only the oldest issues when the pair has a RAW hazard, a memory
// port conflict, or lane A holds a control-flow instruction.
// Optional: define SCHED_STATS_EN to add the stat_dual / stat_single counters.
module dual_issue_scheduler #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          in_pc_a,
    input  logic [XLEN-1:0]          in_instr_a,
    input  logic                     in_vld_a,
    input  logic [XLEN-1:0]          in_pc_b,
    input  logic [XLEN-1:0]          in_instr_b,
    input  logic                     in_vld_b,
    output logic                     in_ready,
    input  logic                     ex_stall,
    input  logic                     flush,
    output logic [XLEN-1:0]          out_pc_a,
    output logic [XLEN-1:0]          out_instr_a,
    output logic                     out_vld_a,
    output logic [XLEN-1:0]          out_pc_b,
    output logic [XLEN-1:0]          out_instr_b,
    output logic                     out_vld_b,
    output logic                     split,
    output logic [$clog2(DEPTH):0]   count
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]              stat_dual,
    output logic [31:0]              stat_single
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // Anything outside the decoded set is treated as writing rd and reading both sources.
    function automatic logic f_known(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
               (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_OP) || (op == OP_IMM);
    endfunction

    // Only stores and branches lack a destination register.
    function automatic logic f_wr_rd(input logic [6:0] op);
        return !((op == OP_STORE) || (op == OP_BRANCH));
    endfunction

    function automatic logic f_rd_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic f_rd_rs2(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH) || !f_known(op);
    endfunction

    function automatic logic f_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    logic [XLEN-1:0] r_pc  [DEPTH];
    logic [XLEN-1:0] r_ins [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic [AW-1:0]   w_h1_ptr;
    logic [AW-1:0]   w_tail_b;
    logic            w_push_a;
    logic            w_push_b;
    logic            w_fire;
    logic            w_two;
    logic            w_raw;
    logic            w_mem;
    logic            w_ctl;
    logic            w_haz;
    logic            w_issue_a;
    logic            w_issue_b;

    assign count    = r_count;
    assign in_ready = (r_count <= CW'(DEPTH - 2));

    // B lands right behind A when both are valid, or in A's place when A is empty.
    assign w_push_a = in_ready & in_vld_a & ~flush;
    assign w_push_b = in_ready & in_vld_b & ~flush;
    assign w_tail_b = r_tail + AW'(w_push_a);

    assign w_h1_ptr = r_head + AW'(1);
    assign w_two    = (r_count >= CW'(2));

    // Pair hazards evaluated on h0/h1; only meaningful when two slots are present.
    assign w_raw = f_wr_rd(r_ins[r_head][6:0]) && (r_ins[r_head][11:7] != 5'd0) &&
                   ((f_rd_rs1(r_ins[w_h1_ptr][6:0]) && (r_ins[w_h1_ptr][19:15] == r_ins[r_head][11:7])) ||
                    (f_rd_rs2(r_ins[w_h1_ptr][6:0]) && (r_ins[w_h1_ptr][24:20] == r_ins[r_head][11:7])));
    assign w_mem = f_mem(r_ins[r_head][6:0]) && f_mem(r_ins[w_h1_ptr][6:0]);
    assign w_ctl = (r_ins[r_head][6:0] == OP_BRANCH) || (r_ins[r_head][6:0] == OP_JAL) ||
                   (r_ins[r_head][6:0] == OP_JALR);
    assign w_haz = w_raw | w_mem | w_ctl;

    assign w_fire    = ~ex_stall & ~flush;
    assign w_issue_a = w_fire & (r_count != '0);
    assign w_issue_b = w_fire & w_two & ~w_haz;

    // Slot storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_pc[r_tail]  <= in_pc_a;
            r_ins[r_tail] <= in_instr_a;
        end
        if (w_push_b) begin
            r_pc[w_tail_b]  <= in_pc_b;
            r_ins[w_tail_b] <= in_instr_b;
        end
    end

    // Queue pointers, occupancy and registered issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            out_pc_a    <= '0;
            out_instr_a <= '0;
            out_vld_a   <= 1'b0;
            out_pc_b    <= '0;
            out_instr_b <= '0;
            out_vld_b   <= 1'b0;
            split       <= 1'b0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            out_vld_a <= 1'b0;
            out_vld_b <= 1'b0;
            split     <= 1'b0;
        end else begin
            r_tail  <= r_tail + AW'(w_push_a) + AW'(w_push_b);
            r_head  <= r_head + AW'(w_issue_a) + AW'(w_issue_b);
            r_count <= r_count + CW'(w_push_a) + CW'(w_push_b) - CW'(w_issue_a) - CW'(w_issue_b);
            if (w_fire) begin
                out_vld_a <= w_issue_a;
                out_vld_b <= w_issue_b;
                split     <= w_two & w_haz;
                if (w_issue_a) begin
                    out_pc_a    <= r_pc[r_head];
                    out_instr_a <= r_ins[r_head];
                end
                if (w_issue_b) begin
                    out_pc_b    <= r_pc[w_h1_ptr];
                    out_instr_b <= r_ins[w_h1_ptr];
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    // Issue statistics; stalled edges are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dual   <= '0;
            stat_single <= '0;
        end else if (flush) begin
            stat_dual   <= '0;
            stat_single <= '0;
        end else if (w_fire) begin
            stat_dual   <= stat_dual + 32'(w_issue_b);
            stat_single <= stat_single + 32'(w_two & w_haz);
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_dual_issue_scheduler;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc_a, in_instr_a, in_pc_b, in_instr_b;
    logic        in_vld_a, in_vld_b, in_ready, ex_stall, flush;
    logic [31:0] out_pc_a, out_instr_a, out_pc_b, out_instr_b;
    logic        out_vld_a, out_vld_b, split;
    logic [2:0]  count;
`ifdef SCHED_STATS_EN
    logic [31:0] stat_dual, stat_single;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADDI2 = 32'h00700113;  // addi x2,x0,7
    localparam logic [31:0] ADD3  = 32'h001081B3;  // add x3,x1,x1
    localparam logic [31:0] LW1   = 32'h00012083;  // lw x1,0(x2)
    localparam logic [31:0] LW3   = 32'h00412183;  // lw x3,4(x2)

    dual_issue_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_pc_a(in_pc_a), .in_instr_a(in_instr_a), .in_vld_a(in_vld_a),
        .in_pc_b(in_pc_b), .in_instr_b(in_instr_b), .in_vld_b(in_vld_b),
        .in_ready(in_ready), .ex_stall(ex_stall), .flush(flush),
        .out_pc_a(out_pc_a), .out_instr_a(out_instr_a), .out_vld_a(out_vld_a),
        .out_pc_b(out_pc_b), .out_instr_b(out_instr_b), .out_vld_b(out_vld_b),
        .split(split), .count(count)
`ifdef SCHED_STATS_EN
        , .stat_dual(stat_dual), .stat_single(stat_single)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: an in-order list of slots plus the last issued lanes.
    typedef struct { logic [31:0] pc; logic [31:0] ins; } slot_t;
    slot_t       mq[$];
    bit          m_va, m_vb, m_split;
    logic [31:0] m_pa, m_ia, m_pb, m_ib;
    int unsigned m_dual, m_single;

    // A pair must split when the ISA-level dependency/resource rules say so.
    function automatic bit must_split(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] oa, ob;
        bit known_a, known_b, wr, r1, r2, raw, mem, ctl;
        oa = a[6:0];
        ob = b[6:0];
        known_a = oa inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        known_b = ob inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        wr  = (oa inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
                          7'b1101111, 7'b1100111}) || !known_a;
        r1  = !(ob inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2  = (ob inside {7'b0110011, 7'b0100011, 7'b1100011}) || !known_b;
        raw = wr && (a[11:7] != 0) &&
              ((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7]));
        mem = (oa inside {7'b0000011, 7'b0100011}) && (ob inside {7'b0000011, 7'b0100011});
        ctl = oa inside {7'b1100011, 7'b1101111, 7'b1100111};
        return raw || mem || ctl;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0] op;
        case ($urandom_range(0, 9))
            0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
            3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b1101111;
            6: op = 7'b1100111;  7: op = 7'b0110111;  8: op = 7'b0010111;
            default: op = 7'b1111111;
        endcase
        return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'd0,
                5'($urandom_range(0, 3)), op};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_va = 0; m_vb = 0; m_split = 0; m_dual = 0; m_single = 0;
    endtask

    task automatic drive(input bit va, input logic [31:0] pa, input logic [31:0] ia,
                         input bit vb, input logic [31:0] pb, input logic [31:0] ib);
        in_vld_a = va; in_pc_a = pa; in_instr_a = ia;
        in_vld_b = vb; in_pc_b = pb; in_instr_b = ib;
    endtask

    // Advance the model by one edge using the inputs now presented, then clock the DUT.
    task automatic tick();
        int  n;
        bit  ready;
        if (flush) begin
            model_clear();
        end else begin
            ready = (DEPTH - mq.size()) >= 2;
            if (!ex_stall) begin
                n = mq.size();
                m_va = (n >= 1);
                m_vb = (n >= 2) && !must_split(mq[0].ins, mq[1].ins);
                m_split = (n >= 2) && !m_vb;
                if (m_va) begin m_pa = mq[0].pc; m_ia = mq[0].ins; end
                if (m_vb) begin m_pb = mq[1].pc; m_ib = mq[1].ins; end
                if (m_vb) m_dual++;
                if (m_split) m_single++;
                if (m_va) void'(mq.pop_front());
                if (m_vb) void'(mq.pop_front());
            end
            if (ready) begin
                if (in_vld_a) mq.push_back('{pc: in_pc_a, ins: in_instr_a});
                if (in_vld_b) mq.push_back('{pc: in_pc_b, ins: in_instr_b});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL por_count: got %0d want 0", count); end
        n_checks++; if (in_ready !== 1'b1 || out_vld_a !== 1'b0 || out_vld_b !== 1'b0 || split !== 1'b0)
            begin n_fail++; $display("FAIL por_outs: rdy=%b va=%b vb=%b split=%b want 1 0 0 0", in_ready, out_vld_a, out_vld_b, split); end
        drive(1, 32'h0, ADDI1, 1, 32'h4, ADDI2); tick();
        drive(1, 32'h8, ADDI1, 1, 32'hC, ADDI2); tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (out_vld_a !== 1'b1 || count !== 3'd2)
            begin n_fail++; $display("FAIL pre_rst_state: va=%b count=%0d want 1 2", out_vld_a, count); end
        rst = 1'b1; #1;
        model_clear();
        n_checks++; if (count !== 3'd0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL midrst_count: count=%0d rdy=%b want 0 1", count, in_ready); end
        n_checks++; if (out_vld_a !== 1'b0 || out_vld_b !== 1'b0 || split !== 1'b0)
            begin n_fail++; $display("FAIL midrst_outs: va=%b vb=%b split=%b want 0", out_vld_a, out_vld_b, split); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pair();
        drive(1, 32'h0, ADDI1, 1, 32'h4, ADDI2); tick();
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (count !== 3'd2 || out_vld_a !== 1'b0)
            begin n_fail++; $display("FAIL pair_push: count=%0d va=%b want 2 0", count, out_vld_a); end
        tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h0 || out_instr_a !== ADDI1)
            begin n_fail++; $display("FAIL pair_lane_a: va=%b pc=%h ins=%h want 1 0 %h", out_vld_a, out_pc_a, out_instr_a, ADDI1); end
        n_checks++; if (out_vld_b !== 1'b1 || out_pc_b !== 32'h4 || out_instr_b !== ADDI2)
            begin n_fail++; $display("FAIL pair_lane_b: vb=%b pc=%h ins=%h want 1 4 %h", out_vld_b, out_pc_b, out_instr_b, ADDI2); end
        n_checks++; if (split !== 1'b0 || count !== 3'd0)
            begin n_fail++; $display("FAIL pair_split_count: split=%b count=%0d want 0 0", split, count); end
    endtask

    task automatic test_raw();
        drive(1, 32'h100, ADDI1, 1, 32'h104, ADD3); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h100 || out_vld_b !== 1'b0 || split !== 1'b1 || count !== 3'd1)
            begin n_fail++; $display("FAIL raw_first: va=%b pc=%h vb=%b split=%b count=%0d want 1 100 0 1 1", out_vld_a, out_pc_a, out_vld_b, split, count); end
        tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h104 || out_instr_a !== ADD3 || out_vld_b !== 1'b0 || split !== 1'b0)
            begin n_fail++; $display("FAIL raw_second: va=%b pc=%h ins=%h vb=%b split=%b want 1 104 %h 0 0", out_vld_a, out_pc_a, out_instr_a, out_vld_b, split, ADD3); end
    endtask

    task automatic test_mem_conflict();
        drive(1, 32'h200, LW1, 1, 32'h204, LW3); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h200 || out_vld_b !== 1'b0 || split !== 1'b1)
            begin n_fail++; $display("FAIL mem_first: va=%b pc=%h vb=%b split=%b want 1 200 0 1", out_vld_a, out_pc_a, out_vld_b, split); end
        tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h204 || out_vld_b !== 1'b0 || split !== 1'b0)
            begin n_fail++; $display("FAIL mem_second: va=%b pc=%h vb=%b split=%b want 1 204 0 0", out_vld_a, out_pc_a, out_vld_b, split); end
        drive(1, 32'h300, LW1, 1, 32'h304, ADDI2); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (out_vld_a !== 1'b1 || out_vld_b !== 1'b1 || out_pc_b !== 32'h304 || split !== 1'b0)
            begin n_fail++; $display("FAIL mem_lw_addi: va=%b vb=%b pcb=%h split=%b want 1 1 304 0", out_vld_a, out_vld_b, out_pc_b, split); end
    endtask

    task automatic test_stall_full();
        ex_stall = 1'b1;
        drive(1, 32'h400, ADDI1, 1, 32'h404, ADDI2); tick();
        n_checks++; if (count !== 3'd2 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL stall_first_push: count=%0d rdy=%b want 2 1", count, in_ready); end
        drive(1, 32'h408, ADDI1, 1, 32'h40C, ADDI2); tick();
        n_checks++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL stall_full: count=%0d rdy=%b want 4 0", count, in_ready); end
        drive(1, 32'h410, ADDI1, 1, 32'h414, ADDI2); tick();
        n_checks++; if (count !== 3'd4)
            begin n_fail++; $display("FAIL stall_overflow: count=%0d want 4", count); end
        n_checks++; if (out_vld_a !== 1'b1 || out_pc_a !== 32'h300 || out_vld_b !== 1'b1 || out_pc_b !== 32'h304 || split !== 1'b0)
            begin n_fail++; $display("FAIL stall_hold: va=%b pca=%h vb=%b pcb=%h split=%b want 1 300 1 304 0", out_vld_a, out_pc_a, out_vld_b, out_pc_b, split); end
        ex_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0); tick();
        n_checks++; if (out_pc_a !== 32'h400 || out_pc_b !== 32'h404 || out_vld_b !== 1'b1 || count !== 3'd2 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL drain_1: pca=%h pcb=%h vb=%b count=%0d rdy=%b want 400 404 1 2 1", out_pc_a, out_pc_b, out_vld_b, count, in_ready); end
        tick();
        n_checks++; if (out_pc_a !== 32'h408 || out_pc_b !== 32'h40C || out_vld_b !== 1'b1 || count !== 3'd0)
            begin n_fail++; $display("FAIL drain_2: pca=%h pcb=%h vb=%b count=%0d want 408 40c 1 0", out_pc_a, out_pc_b, out_vld_b, count); end
        tick();
        n_checks++; if (out_vld_a !== 1'b0 || out_vld_b !== 1'b0)
            begin n_fail++; $display("FAIL drain_empty: va=%b vb=%b want 0 0", out_vld_a, out_vld_b); end
    endtask

    task automatic test_flush();
        drive(1, 32'h500, ADDI1, 1, 32'h504, ADD3); tick();
        drive(1, 32'h508, ADDI1, 1, 32'h50C, ADDI2); tick();
        n_checks++; if (count !== 3'd3 || out_vld_a !== 1'b1 || out_pc_a !== 32'h500)
            begin n_fail++; $display("FAIL flush_setup: count=%0d va=%b pc=%h want 3 1 500", count, out_vld_a, out_pc_a); end
        flush = 1'b1;
        drive(1, 32'h510, ADDI1, 1, 32'h514, ADDI2); tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        n_checks++; if (count !== 3'd0 || out_vld_a !== 1'b0 || out_vld_b !== 1'b0 || split !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_state: count=%0d va=%b vb=%b split=%b rdy=%b want 0 0 0 0 1", count, out_vld_a, out_vld_b, split, in_ready); end
        tick();
        n_checks++; if (count !== 3'd0 || out_vld_a !== 1'b0)
            begin n_fail++; $display("FAIL flush_dropped: count=%0d va=%b want 0 0", count, out_vld_a); end
    endtask

    task automatic test_random();
        logic [31:0] pc = 32'h1000;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive($urandom_range(0, 3) != 0, pc, rand_ins(), $urandom_range(0, 2) != 0, pc + 4, rand_ins());
            pc = pc + 8;
            ex_stall = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++; if (count !== mq.size() || in_ready !== ((DEPTH - mq.size()) >= 2))
                begin n_fail++; $display("FAIL rnd_count c%0d: count=%0d rdy=%b want %0d", cyc, count, in_ready, mq.size()); end
            n_checks++; if (out_vld_a !== m_va || out_vld_b !== m_vb || split !== m_split)
                begin n_fail++; $display("FAIL rnd_valid c%0d: va=%b vb=%b split=%b want %b %b %b", cyc, out_vld_a, out_vld_b, split, m_va, m_vb, m_split); end
            if (m_va) begin
                n_checks++; if (out_pc_a !== m_pa || out_instr_a !== m_ia)
                    begin n_fail++; $display("FAIL rnd_lane_a c%0d: pc=%h ins=%h want %h %h", cyc, out_pc_a, out_instr_a, m_pa, m_ia); end
            end
            if (m_vb) begin
                n_checks++; if (out_pc_b !== m_pb || out_instr_b !== m_ib)
                    begin n_fail++; $display("FAIL rnd_lane_b c%0d: pc=%h ins=%h want %h %h", cyc, out_pc_b, out_instr_b, m_pb, m_ib); end
            end
`ifdef SCHED_STATS_EN
            n_checks++; if (stat_dual !== m_dual || stat_single !== m_single)
                begin n_fail++; $display("FAIL rnd_stats c%0d: dual=%0d single=%0d want %0d %0d", cyc, stat_dual, stat_single, m_dual, m_single); end
`endif
        end
        ex_stall = 1'b0;
        flush    = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_pair();
        test_raw();
        test_mem_conflict();
        test_stall_full();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
